// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and writer side of the 35-bit IF/ID register.
// Holds the PC, requests instructions from memory, builds the IF/ID packet
// {flags, instruction, pc+2} and handles stalls, branch redirects, memory
// wait states and HALT.
// Optional feature macro: FETCH_PERF_EN adds saturating fetch/bubble counters.

module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000,
    parameter logic [3:0]  HALT_OP   = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic [2:0]  flags,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    input  logic [15:0] imem_data,
    input  logic        imem_valid,
    output logic [34:0] ifid_d,
    output logic        ifid_wen,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] fetch_count,
    output logic [15:0] bubble_count
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pc;
    logic [15:0] pc_next;
    logic [15:0] pc_plus2;
    logic        hold_valid;
    logic        hold_valid_next;
    logic [15:0] hold_instr;
    logic [15:0] hold_instr_next;
    logic        issue_real;
    logic [15:0] issue_instr;

    assign pc_plus2  = pc + 16'd2;
    assign imem_addr = pc;

    // Next-state and output decode: reset, then redirect, then stall, then normal fetch
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        hold_valid_next = hold_valid;
        hold_instr_next = hold_instr;
        imem_req        = 1'b0;
        ifid_wen        = 1'b1;
        halted          = (state == HALT);
        issue_real      = 1'b0;
        issue_instr     = NOP_INSTR;
        ifid_d          = {flags, NOP_INSTR, pc_plus2};

        if (rst) begin
            halted = 1'b0;
            ifid_d = {3'b000, NOP_INSTR, 16'h0000};
        end else if (branch_taken) begin
            pc_next         = branch_target;
            hold_valid_next = 1'b0;
            state_next      = FETCH;
        end else if (stall) begin
            ifid_wen = 1'b0;
            if (state != HALT) begin
                imem_req = !hold_valid;
                if (!hold_valid && imem_valid) begin
                    hold_instr_next = imem_data;
                    hold_valid_next = 1'b1;
                end
            end
        end else if (state != HALT) begin
            if (hold_valid) begin
                issue_real      = 1'b1;
                issue_instr     = hold_instr;
                hold_valid_next = 1'b0;
            end else begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    issue_real  = 1'b1;
                    issue_instr = imem_data;
                end else begin
                    state_next = WAIT;
                end
            end
            if (issue_real) begin
                ifid_d = {flags, issue_instr, pc_plus2};
                if (issue_instr[15:12] == HALT_OP) begin
                    state_next = HALT;
                end else begin
                    pc_next    = pc_plus2;
                    state_next = FETCH;
                end
            end
        end
    end

    // State, PC and holding-buffer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            hold_valid <= 1'b0;
            hold_instr <= NOP_INSTR;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            hold_valid <= hold_valid_next;
            hold_instr <= hold_instr_next;
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating counters of real instructions and bubbles written into IF/ID
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count  <= 16'h0000;
            bubble_count <= 16'h0000;
        end else if (ifid_wen) begin
            if (issue_real) begin
                if (fetch_count != 16'hFFFF) begin
                    fetch_count <= fetch_count + 16'd1;
                end
            end else if (bubble_count != 16'hFFFF) begin
                bubble_count <= bubble_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized bench for fetch_stage, checked
// against a behavioural model of the fetch rules (PC, halted flag and a
// queue standing in for the holding buffer).
// Optional feature macro: FETCH_PERF_EN also checks the perf counters.

module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'h0000;
    localparam logic [2:0]  FL  = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [2:0]  flags;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic [34:0] ifid_d;
    logic        ifid_wen;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count;
    logic [15:0] bubble_count;
`endif

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .flags        (flags),
        .imem_addr    (imem_addr),
        .imem_req     (imem_req),
        .imem_data    (imem_data),
        .imem_valid   (imem_valid),
        .ifid_d       (ifid_d),
        .ifid_wen     (ifid_wen),
        .halted       (halted)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count  (fetch_count),
        .bubble_count (bubble_count)
`endif
    );

    int check_count = 0;
    int pass_count  = 0;

    logic [15:0] m_pc = 16'h0000;
    logic        m_halted = 1'b0;
    logic [15:0] m_hold[$];
    int          m_fetch = 0;
    int          m_bubble = 0;

    logic [15:0] n_pc;
    logic        n_halted;
    logic        n_push;
    logic        n_pop;
    logic        n_clear;
    logic [15:0] n_push_val;
    logic        n_rst;
    logic        n_real;

    logic        exp_req;
    logic        exp_wen;
    logic        exp_halted;
    logic [34:0] exp_d;

    task automatic checkOutput(input string tag, input logic [34:0] observed, input logic [34:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, predict outputs from the model and compare
    task automatic applyStimulus(input logic r, input logic br, input logic [15:0] tgt,
                                 input logic st, input logic v, input logic [15:0] dat,
                                 input logic [2:0] fl);
        logic        have;
        logic [15:0] instr;
        rst           = r;
        branch_taken  = br;
        branch_target = tgt;
        stall         = st;
        imem_valid    = v;
        imem_data     = dat;
        flags         = fl;
        #1;
        exp_req    = 1'b0;
        exp_wen    = 1'b1;
        exp_halted = m_halted;
        exp_d      = {fl, NOP, m_pc + 16'd2};
        n_pc       = m_pc;
        n_halted   = m_halted;
        n_push     = 1'b0;
        n_pop      = 1'b0;
        n_clear    = 1'b0;
        n_push_val = dat;
        have       = 1'b0;
        instr      = NOP;
        if (r) begin
            exp_halted = 1'b0;
            exp_d      = {3'b000, NOP, 16'h0000};
            n_pc       = 16'h0000;
            n_halted   = 1'b0;
            n_clear    = 1'b1;
        end else if (br) begin
            n_pc     = tgt;
            n_halted = 1'b0;
            n_clear  = 1'b1;
        end else if (st) begin
            exp_wen = 1'b0;
            if (!m_halted && m_hold.size() == 0) begin
                exp_req = 1'b1;
                n_push  = v;
            end
        end else if (!m_halted) begin
            if (m_hold.size() != 0) begin
                have  = 1'b1;
                instr = m_hold[0];
                n_pop = 1'b1;
            end else begin
                exp_req = 1'b1;
                if (v) begin
                    have  = 1'b1;
                    instr = dat;
                end
            end
            if (have) begin
                exp_d = {fl, instr, m_pc + 16'd2};
                if (instr[15:12] == 4'hF) n_halted = 1'b1;
                else n_pc = m_pc + 16'd2;
            end
        end
        n_rst  = r;
        n_real = have;
        if (!r) checkOutput("imem_addr", {19'b0, imem_addr}, {19'b0, m_pc});
        checkOutput("imem_req", {34'b0, imem_req}, {34'b0, exp_req});
        checkOutput("ifid_wen", {34'b0, ifid_wen}, {34'b0, exp_wen});
        checkOutput("halted", {34'b0, halted}, {34'b0, exp_halted});
        if (exp_wen) checkOutput("ifid_d", ifid_d, exp_d);
`ifdef FETCH_PERF_EN
        checkOutput("fetch_count", {19'b0, fetch_count}, {19'b0, m_fetch[15:0]});
        checkOutput("bubble_count", {19'b0, bubble_count}, {19'b0, m_bubble[15:0]});
`endif
    endtask

    // Advance one clock edge and commit the model's predicted next state
    task automatic stepClock();
        @(posedge clk);
        m_pc     = n_pc;
        m_halted = n_halted;
        if (n_clear) m_hold.delete();
        else if (n_pop) void'(m_hold.pop_front());
        else if (n_push) m_hold.push_back(n_push_val);
        if (n_rst) begin
            m_fetch  = 0;
            m_bubble = 0;
        end else if (exp_wen) begin
            if (n_real) m_fetch = (m_fetch < 65535) ? m_fetch + 1 : 65535;
            else m_bubble = (m_bubble < 65535) ? m_bubble + 1 : 65535;
        end
        @(negedge clk);
    endtask

    initial begin
        int unsigned rnd;
        logic [15:0] tgt;
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0;
        imem_valid = 1'b0; imem_data = 16'h0; flags = 3'b000;
        @(negedge clk);

        // Reset packet
        applyStimulus(1, 0, 16'h0, 0, 0, 16'h0, FL);
        checkOutput("rst_pkt", ifid_d, 35'h0);
        stepClock();
        applyStimulus(1, 0, 16'h0, 0, 0, 16'h0, FL);
        stepClock();

        // Zero-wait fetches
        applyStimulus(0, 0, 16'h0, 0, 1, 16'h1234, FL);
        checkOutput("pkt_1234", ifid_d, {FL, 16'h1234, 16'h0002});
        stepClock();
        applyStimulus(0, 0, 16'h0, 0, 1, 16'h5678, FL);
        checkOutput("addr_0002", {19'b0, imem_addr}, {19'b0, 16'h0002});
        checkOutput("pkt_5678", ifid_d, {FL, 16'h5678, 16'h0004});
        stepClock();

        // Two wait states, then the response
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, FL);
            checkOutput("wait_bubble", ifid_d, {FL, NOP, 16'h0006});
            stepClock();
        end
        applyStimulus(0, 0, 16'h0, 0, 1, 16'h1111, FL);
        checkOutput("pkt_after_wait", ifid_d, {FL, 16'h1111, 16'h0006});
        stepClock();

        // Stall with a response captured into the holding buffer
        applyStimulus(0, 0, 16'h0, 1, 1, 16'hABCD, FL);
        stepClock();
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0, FL);
        stepClock();
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0, FL);
        stepClock();
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, FL);
        checkOutput("held_pkt", ifid_d, {FL, 16'hABCD, 16'h0008});
        stepClock();

        // Enter WAIT, then redirect under stall with a late old response
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, FL);
        stepClock();
        applyStimulus(0, 1, 16'h0100, 1, 1, 16'hBEEF, FL);
        checkOutput("branch_bubble", ifid_d, {FL, NOP, 16'h000A});
        stepClock();
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, FL);
        checkOutput("addr_0100", {19'b0, imem_addr}, {19'b0, 16'h0100});
        stepClock();

        // PC wrap at the top of the address space
        applyStimulus(0, 1, 16'hFFFE, 0, 0, 16'h0, FL);
        stepClock();
        applyStimulus(0, 0, 16'h0, 0, 1, 16'h0001, FL);
        checkOutput("wrap_pkt", ifid_d, {FL, 16'h0001, 16'h0000});
        stepClock();
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, FL);
        checkOutput("wrap_addr", {19'b0, imem_addr}, {19'b0, 16'h0000});
        stepClock();

        // HALT and exit by branch
        applyStimulus(0, 1, 16'h0020, 0, 0, 16'h0, FL);
        stepClock();
        applyStimulus(0, 0, 16'h0, 0, 1, 16'hF000, FL);
        checkOutput("halt_pkt", ifid_d, {FL, 16'hF000, 16'h0022});
        stepClock();
        applyStimulus(0, 0, 16'h0, 0, 1, 16'h1234, FL);
        checkOutput("halt_flag", {34'b0, halted}, 35'd1);
        checkOutput("halt_addr", {19'b0, imem_addr}, {19'b0, 16'h0020});
        stepClock();
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0, FL);
        stepClock();
        applyStimulus(0, 1, 16'h0040, 0, 0, 16'h0, FL);
        stepClock();
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, FL);
        checkOutput("unhalt", {34'b0, halted}, 35'd0);
        checkOutput("addr_0040", {19'b0, imem_addr}, {19'b0, 16'h0040});
        stepClock();

`ifdef FETCH_PERF_EN
        // Five real fetches and two bubbles after a reset
        applyStimulus(1, 0, 16'h0, 0, 0, 16'h0, FL);
        stepClock();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 16'h0, 0, 1, 16'h0ABC, FL);
            stepClock();
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, FL);
            stepClock();
        end
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0, FL);
        checkOutput("perf_fetch5", {19'b0, fetch_count}, {19'b0, 16'd5});
        checkOutput("perf_bubble2", {19'b0, bubble_count}, {19'b0, 16'd2});
        stepClock();
        applyStimulus(1, 0, 16'h0, 0, 0, 16'h0, FL);
        stepClock();
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0, FL);
        checkOutput("perf_clr_fetch", {19'b0, fetch_count}, 35'd0);
        checkOutput("perf_clr_bubble", {19'b0, bubble_count}, 35'd0);
        stepClock();
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic r, br, st, v;
            logic [15:0] dat;
            logic [2:0]  fl;
            rnd = $urandom;
            r   = ($urandom_range(0, 199) == 0);
            br  = ($urandom_range(0, 11) == 0);
            st  = ($urandom_range(0, 4) == 0);
            v   = ($urandom_range(0, 1) == 1);
            dat = rnd[15:0];
            fl  = rnd[18:16];
            rnd = $urandom;
            tgt = ($urandom_range(0, 7) == 0) ? 16'hFFFE : {rnd[15:1], 1'b0};
            applyStimulus(r, br, tgt, st, v, dat, fl);
            stepClock();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage; the writer side of the 35-bit IF/ID pipeline register.
- Holds the PC and issues requests to instruction memory.
- Builds the IF/ID packet {flags[2:0], instruction[15:0], pc_plus2[15:0]} and its write enable.
- Handles hazard stalls, branch redirects, memory wait states and HALT.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0000, instruction word used for bubbles.
- HALT_OP, 4'hF, opcode in instr[15:12] that halts fetch.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit hold request: freeze PC and IF/ID contents.
- branch_taken  in  1  redirect request from decode.
- branch_target  in  16  redirect PC, valid with branch_taken.
- flags  in  3  current {Z,V,N} flag values, forwarded into the packet.
- imem_addr  out  16  fetch address; always equals the PC register.
- imem_req  out  1  fetch request; deasserting it cancels any outstanding request.
- imem_data  in  16  instruction word, valid with imem_valid.
- imem_valid  in  1  memory response strobe; may arrive in the request cycle or later.
- ifid_d  out  35  IF/ID packet: [34:32] flags, [31:16] instruction, [15:0] pc+2.
- ifid_wen  out  1  IF/ID write enable.
- halted  out  1  high while in HALT.

Behaviour:
- Registers:
  - pc (16 bits).
  - state ∈ {FETCH, WAIT, HALT}.
  - hold_valid (1 bit) and hold_instr (16 bits), forming a one-entry holding buffer.
- Reset (rst=1 at clock edge): pc<=RESET_PC; state<=FETCH; hold_valid<=0.
  - While rst=1: imem_req=0, ifid_wen=1, ifid_d={3'b000, NOP_INSTR, 16'h0000}, halted=0.
- Outputs are combinational from state and inputs; IF/ID captures on the same edge, giving zero added latency.
- Bubble packet: {flags, NOP_INSTR, pc+2}.
- Priority order per cycle: rst > branch_taken > stall > normal operation.
- branch_taken=1, any state:
  - pc<=branch_target; hold_valid<=0; state<=FETCH.
  - imem_req=0 this cycle, cancelling any in-flight fetch; its response is ignored.
  - ifid_wen=1 with the bubble packet, squashing the wrong-path instruction.
- stall=1 (no branch):
  - ifid_wen=0; pc and state unchanged.
  - imem_req held as in the current state.
  - If imem_valid arrives and hold_valid=0: hold_instr<=imem_data, hold_valid<=1.
- FETCH / WAIT, no stall, no branch:
  - If hold_valid=1, issue the buffered instruction.
    - imem_req=0.
    - ifid_d={flags, hold_instr, pc+2}; ifid_wen=1.
    - hold_valid<=0; pc<=pc+2 unless HALT (below).
  - Else imem_req=1.
    - On imem_valid: ifid_d={flags, imem_data, pc+2}; ifid_wen=1; pc<=pc+2; state<=FETCH.
    - Without imem_valid: ifid_wen=1 with the bubble packet; state<=WAIT.
- HALT detect: if the issued instruction has [15:12]==HALT_OP:
  - The halt instruction is passed down normally.
  - pc not incremented; state<=HALT.
- HALT: imem_req=0; ifid_wen=1 with the bubble packet; halted=1.
  - Exit only by branch_taken (older branch redirect) or rst.
- PC arithmetic is modulo 2^16; 16'hFFFE+2 wraps to 16'h0000.
- Stall asserted while in HALT: no effect beyond ifid_wen=0.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds output fetch_count[15:0]: counts cycles where ifid_wen=1 with a non-bubble instruction.
  - Adds output bubble_count[15:0]: counts cycles where ifid_wen=1 with a bubble.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset then zero-wait memory returning 16'h1234, 16'h5678 → packets pc+2=0002/instr 1234, then 0004/5678; ifid_wen=1 each cycle; imem_addr=0000, 0002.
- imem_valid delayed 2 cycles at pc=0004 → two bubble packets (NOP_INSTR, pc+2=0006) with imem_req held; then the real instruction; pc<=0006.
- stall=1 for 3 cycles, imem_valid arriving during stall with 16'hABCD → ifid_wen=0 throughout; after release, packet instr=ABCD issued with imem_req=0, then normal fetch resumes at pc+2.
- branch_taken=1 with branch_target=0x0100 while in WAIT with stall=1 → bubble written; imem_req=0; next cycle imem_addr=0100; late response for old PC ignored.
- Fetch 16'hF000 at pc=0x0020 → halt packet passed down; halted=1; imem_req=0; pc stays 0020; bubbles thereafter. Then branch_taken to 0x0040 → halted=0, fetch from 0040.
- With FETCH_PERF_EN: 5 real fetches plus 2 bubbles → fetch_count=5, bubble_count=2; rst clears both to 0.
